dmem_access_ctrl: RTL and testbench

//  Initiator side of the data-memory port in the multi-cycle CPU. Takes one load/store

---
 rtl/dmem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - data-memory port initiator for the multi-cycle CPU
// Sub-word stores are read-modify-write; loads are lane-selected and extended in READ.
module dmem_access_ctrl #(
   parameter int MEM_BYTES  = 21,
   parameter bit DROP_CHECK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [3:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ready,
   output logic        done,
   output logic        err,
   output logic        wr_drop,
   output logic [31:0] rdata,
   output logic [31:0] DAddr,
   output logic [31:0] DataIn,
   output logic        RW,
   input  logic [31:0] DataOut
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WRITE, S_DONE, S_ERR} state_t;

   state_t      state_q, state_d;
   logic [3:0]  op_q;
   logic [1:0]  lane_q;
   logic [15:0] wdata_q;
   logic [31:0] daddr_q, datain_q, rdata_q;

   logic [31:0] req_base;
   logic        req_bad;
   logic [31:0] merged_word;
   logic [31:0] lane_word;
   logic [31:0] load_val;

   assign req_base = {addr[31:2], 2'b00};

   always_comb begin
      req_bad = 1'b0;
      if (op[1:0] == 2'b11)
         req_bad = 1'b1;
      else if (op[1:0] == 2'b01 && addr[0])
         req_bad = 1'b1;
      else if (op[1:0] == 2'b10 && addr[1:0] != 2'b00)
         req_bad = 1'b1;
      else if (({1'b0, req_base} + 33'd3) >= 33'(MEM_BYTES))
         req_bad = 1'b1;
   end

   // Store merge and load extraction both work on the word DMem returns during READ
   always_comb begin
      merged_word = DataOut;
      if (op_q[1:0] == 2'b00) begin
         case (lane_q)
            2'd0:    merged_word = {DataOut[31:8], wdata_q[7:0]};
            2'd1:    merged_word = {DataOut[31:16], wdata_q[7:0], DataOut[7:0]};
            2'd2:    merged_word = {DataOut[31:24], wdata_q[7:0], DataOut[15:0]};
            default: merged_word = {wdata_q[7:0], DataOut[23:0]};
         endcase
      end else if (op_q[1:0] == 2'b01) begin
         merged_word = lane_q[1] ? {wdata_q, DataOut[15:0]} : {DataOut[31:16], wdata_q};
      end
   end

   always_comb begin
      lane_word = DataOut >> {lane_q, 3'b000};
      load_val  = DataOut;
      if (op_q[1:0] == 2'b00)
         load_val = op_q[2] ? {24'd0, lane_word[7:0]} : {{24{lane_word[7]}}, lane_word[7:0]};
      else if (op_q[1:0] == 2'b01)
         load_val = op_q[2] ? {16'd0, lane_word[15:0]} : {{16{lane_word[15]}}, lane_word[15:0]};
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (req_bad)
                  state_d = S_ERR;
               else if (op[3] && op[1:0] == 2'b10)
                  state_d = S_WRITE;
               else
                  state_d = S_READ;
            end
         end
         S_READ:  state_d = op_q[3] ? S_WRITE : S_DONE;
         S_WRITE: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= 4'd0;
         lane_q   <= 2'd0;
         wdata_q  <= 16'd0;
         daddr_q  <= 32'd0;
         datain_q <= 32'd0;
         rdata_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  op_q    <= op;
                  lane_q  <= addr[1:0];
                  wdata_q <= wdata[15:0];
                  // Rejected requests leave the memory bus untouched
                  if (!req_bad) begin
                     daddr_q <= req_base;
                     if (op[3] && op[1:0] == 2'b10)
                        datain_q <= wdata;
                  end
               end
            end
            S_READ: begin
               if (op_q[3])
                  datain_q <= merged_word;
               else
                  rdata_q <= load_val;
            end
            default: ;
         endcase
      end
   end

   assign ready  = (state_q == S_IDLE);
   assign done   = (state_q == S_DONE) || (state_q == S_ERR);
   assign err    = (state_q == S_ERR);
   assign RW     = (state_q == S_WRITE);
   assign DAddr  = daddr_q;
   assign DataIn = datain_q;
   assign rdata  = rdata_q;

   generate
      if (DROP_CHECK) begin : g_drop
         assign wr_drop = (state_q == S_DONE) && op_q[3] &&
                          ((daddr_q == 32'd0) || (datain_q == 32'd0));
      end else begin : g_no_drop
         assign wr_drop = 1'b0;
      end
   endgenerate

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - directed self-checking bench for dmem_access_ctrl
// Includes a byte-array DMem model that writes on negedge and drops base-0 or zero-word writes.
module tb_dmem_access_ctrl;

   localparam logic [3:0] OP_LB  = 4'b0000;
   localparam logic [3:0] OP_LBU = 4'b0100;
   localparam logic [3:0] OP_LH  = 4'b0001;
   localparam logic [3:0] OP_LW  = 4'b0010;
   localparam logic [3:0] OP_BAD = 4'b0011;
   localparam logic [3:0] OP_SB  = 4'b1000;
   localparam logic [3:0] OP_SW  = 4'b1010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] wdata = 32'd0;
   logic        ready, done, err, wr_drop, RW;
   logic [31:0] rdata, DAddr, DataIn, DataOut;

   logic [7:0]  mem [0:20];
   int          total = 0;
   int          errs  = 0;

   int          lat, rwc;
   logic [31:0] wd, wa;
   logic        e, dr;

   dmem_access_ctrl dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .addr(addr), .wdata(wdata),
      .ready(ready), .done(done), .err(err), .wr_drop(wr_drop), .rdata(rdata),
      .DAddr(DAddr), .DataIn(DataIn), .RW(RW), .DataOut(DataOut)
   );

   always #5 clk = ~clk;

   always_comb begin
      DataOut = 32'd0;
      if (DAddr + 32'd3 < 32'd21)
         DataOut = {mem[DAddr+3], mem[DAddr+2], mem[DAddr+1], mem[DAddr]};
   end

   always @(negedge clk) begin
      if (RW && DAddr != 32'd0 && DataIn != 32'd0 && DAddr + 32'd3 < 32'd21) begin
         mem[DAddr]   <= DataIn[7:0];
         mem[DAddr+1] <= DataIn[15:8];
         mem[DAddr+2] <= DataIn[23:16];
         mem[DAddr+3] <= DataIn[31:24];
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issues one request and follows it to done, recording the bus activity seen.
   task automatic run(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
      logic got_done;
      op = o; addr = a; wdata = d; req = 1'b1;
      lat = 0; rwc = 0; wd = 32'd0; wa = 32'd0; e = 1'b0; dr = 1'b0; got_done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         lat++;
         if (RW) begin
            rwc++;
            wd = DataIn;
            wa = DAddr;
         end
         if (done) begin
            e = err;
            dr = wr_drop;
            got_done = 1'b1;
            break;
         end
      end
      req = 1'b0;
      check("done_seen", {31'd0, got_done}, 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 21; i++) mem[i] = 8'h00;

      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_rw",    {31'd0, RW},    32'd0);
      check("rst_done",  {31'd0, done},  32'd0);
      check("rst_daddr", DAddr, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      rst = 1'b0;

      run(OP_SW, 32'd4, 32'h11223344);
      check("sw_lat",   lat, 32'd2);
      check("sw_rwc",   rwc, 32'd1);
      check("sw_daddr", wa,  32'd4);
      check("sw_datain", wd, 32'h11223344);
      check("sw_err",   {31'd0, e}, 32'd0);
      check("sw_mem",   {mem[7], mem[6], mem[5], mem[4]}, 32'h11223344);

      run(OP_LW, 32'd4, 32'd0);
      check("lw_rwc",   rwc, 32'd0);
      check("lw_rdata", rdata, 32'h11223344);

      run(OP_SB, 32'd5, 32'h000000AB);
      check("sb_lat",    lat, 32'd3);
      check("sb_rwc",    rwc, 32'd1);
      check("sb_datain", wd,  32'h1122AB44);

      run(OP_LB, 32'd5, 32'd0);
      check("lb_rdata", rdata, 32'hFFFFFFAB);
      run(OP_LBU, 32'd5, 32'd0);
      check("lbu_rdata", rdata, 32'h000000AB);
      run(OP_LH, 32'd6, 32'd0);
      check("lh_rdata", rdata, 32'h00001122);

      run(OP_LH, 32'd5, 32'd0);
      check("lh_mis_err",   {31'd0, e}, 32'd1);
      check("lh_mis_lat",   lat, 32'd1);
      check("lh_mis_rwc",   rwc, 32'd0);
      check("lh_mis_rdata", rdata, 32'h00001122);
      run(OP_LW, 32'd20, 32'd0);
      check("lw_range_err", {31'd0, e}, 32'd1);
      run(OP_BAD, 32'd0, 32'd0);
      check("size11_err", {31'd0, e}, 32'd1);

      run(OP_SW, 32'd0, 32'h00000005);
      check("sw0_drop", {31'd0, dr}, 32'd1);
      run(OP_SW, 32'd8, 32'h00000000);
      check("swz_drop", {31'd0, dr}, 32'd1);
      run(OP_SW, 32'd8, 32'h00000007);
      check("sw8_drop", {31'd0, dr}, 32'd0);
      check("sw8_mem",  {mem[11], mem[10], mem[9], mem[8]}, 32'h00000007);

      op = OP_SB; addr = 32'd9; wdata = 32'h000000CC; req = 1'b1;
      @(posedge clk); #1;
      check("rst_rd_rw", {31'd0, RW}, 32'd0);
      rst = 1'b1; req = 1'b0;
      @(posedge clk); #1;
      check("rst_rd_rw2",   {31'd0, RW},    32'd0);
      check("rst_rd_done",  {31'd0, done},  32'd0);
      check("rst_rd_ready", {31'd0, ready}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_rd_done2", {31'd0, done}, 32'd0);
      check("rst_rd_mem",   {24'd0, mem[9]}, 32'd0);

      run(OP_LW, 32'd8, 32'd0);
      check("post_rst_err",   {31'd0, e}, 32'd0);
      check("post_rst_rdata", rdata, 32'h00000007);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
      $finish;
   end

endmodule
